// File: rtl/bitnet_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response stream into AXI4-Lite transactions.
// Optional per-transaction watchdog enabled by defining BITNET_AXIM_TIMEOUT_EN.
module bitnet_axi_lite_master #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  accept;
  logic                  timeout_hit;

  // A command arriving while reset is held would be discarded, so it is never acknowledged.
  assign cmd_ready = (state_q == S_IDLE) && !areset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef BITNET_AXIM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  assign in_wait     = (state_q inside {S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA});
  assign timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (in_wait && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Idle sinks late responses from an abandoned transaction; the timeout cycle itself handshakes nothing.
  assign m_axi_bready = (state_q == S_IDLE) || ((state_q == S_WR_RESP) && !timeout_hit);
  assign m_axi_rready = (state_q == S_IDLE) || ((state_q == S_RD_DATA) && !timeout_hit);
`else
  assign timeout_hit  = 1'b0;
  assign m_axi_bready = (state_q == S_WR_RESP);
  assign m_axi_rready = (state_q == S_RD_DATA);
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR_ADDR_DATA: begin
        // Address and data channels complete independently, in either order.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abandoning the transaction overrides whatever the wait state decided this cycle.
    if (timeout_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b11;
      rsp_timeout_d = 1'b1;
      state_d       = S_RSP;
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;

  assign rsp_valid   = (state_q == S_RSP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bitnet_axi_lite_master.sv
// Bench for bitnet_axi_lite_master: register-file slave model with programmable channel delays,
// a protocol monitor, a table of directed transactions and hand-written corner sequences.
module tb_bitnet_axi_lite_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  bitnet_axi_lite_master #(.ADDR_W(6), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

`ifdef BITNET_AXIM_TIMEOUT_EN
  localparam logic [1:0] IDLE_RDY = 2'b11;
`else
  localparam logic [1:0] IDLE_RDY = 2'b00;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model (word 14 = 0x38 answers SLVERR) ----------------
  logic [31:0] mem [16];
  int          aw_delay = 0, w_delay = 0;
  bit          ar_never = 1'b0;
  int          aw_wait, w_wait;
  logic        got_aw, got_w, r_pend;
  logic [5:0]  aw_addr_s, ar_addr_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;

  always @(posedge aclk) begin
    if (areset) begin
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
      aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      aw_addr_s <= '0; ar_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h1122_3344;
      mem[8]  <= 32'h0001_0000;
      mem[9]  <= 32'd999;
      mem[15] <= 32'hDEAD_BEEF;
    end else begin
      m_axi_awready <= 1'b0;
      if (m_axi_awvalid && !m_axi_awready && !got_aw) begin
        if (aw_wait >= aw_delay) m_axi_awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        got_aw <= 1'b1; aw_addr_s <= m_axi_awaddr; aw_wait <= 0;
      end
      m_axi_wready <= 1'b0;
      if (m_axi_wvalid && !m_axi_wready && !got_w) begin
        if (w_wait >= w_delay) m_axi_wready <= 1'b1;
        else w_wait <= w_wait + 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        got_w <= 1'b1; w_data_s <= m_axi_wdata; w_strb_s <= m_axi_wstrb; w_wait <= 0;
      end
      if (got_aw && got_w && !m_axi_bvalid) begin
        if (aw_addr_s[5:2] == 4'hE) begin
          m_axi_bresp <= 2'b10;
        end else begin
          m_axi_bresp <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (w_strb_s[b]) mem[aw_addr_s[5:2]][8*b +: 8] <= w_data_s[8*b +: 8];
        end
        m_axi_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      m_axi_arready <= 1'b0;
      if (m_axi_arvalid && !m_axi_arready && !r_pend && !m_axi_rvalid && !ar_never)
        m_axi_arready <= 1'b1;
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1'b1; ar_addr_s <= m_axi_araddr;
      end
      if (r_pend) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= (ar_addr_s[5:2] == 4'hE) ? 32'h0 : mem[ar_addr_s[5:2]];
        m_axi_rresp  <= (ar_addr_s[5:2] == 4'hE) ? 2'b10 : 2'b00;
        r_pend       <= 1'b0;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  int          cyc = 0, viol = 0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_cnt = 0, ar_hs_cnt = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;
  logic        aw_hs_q = 1'b0, w_hs_q = 1'b0, aw_pend_q = 1'b0, w_pend_q = 1'b0;
  logic [5:0]  aw_addr_q = '0;
  logic [31:0] w_data_q = '0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (areset) begin
      aw_hs_q <= 1'b0; w_hs_q <= 1'b0; aw_pend_q <= 1'b0; w_pend_q <= 1'b0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin aw_hs_cnt <= aw_hs_cnt + 1; aw_hs_cyc <= cyc; end
      if (m_axi_wvalid && m_axi_wready)   begin w_hs_cnt  <= w_hs_cnt + 1;  w_hs_cyc  <= cyc; end
      if (m_axi_bvalid && m_axi_bready)   b_cnt     <= b_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) ar_hs_cnt <= ar_hs_cnt + 1;
      if ((aw_hs_q && m_axi_awvalid) || (w_hs_q && m_axi_wvalid)) viol <= viol + 1;
      if ((aw_pend_q && (!m_axi_awvalid || m_axi_awaddr != aw_addr_q)) ||
          (w_pend_q && (!m_axi_wvalid || m_axi_wdata != w_data_q)))    viol <= viol + 1;
      if (m_axi_awprot != 3'b000 || m_axi_arprot != 3'b000)            viol <= viol + 1;
      aw_hs_q   <= m_axi_awvalid && m_axi_awready;
      w_hs_q    <= m_axi_wvalid && m_axi_wready;
      aw_pend_q <= m_axi_awvalid && !m_axi_awready;
      w_pend_q  <= m_axi_wvalid && !m_axi_wready;
      aw_addr_q <= m_axi_awaddr;
      w_data_q  <= m_axi_wdata;
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic to);
    int n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge aclk); n++; end
    check("rsp_arrived", rsp_valid, 1'b1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rs,
                        output logic to);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 2000) begin @(negedge aclk); n++; end
    check("cmd_ready", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    if (wr) begin
      check("wr_valids_1cyc", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b110);
      check("wr_fields", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, {a, d, s});
    end else begin
      check("rd_valids_1cyc", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b001);
      check("rd_addr", m_axi_araddr, a);
    end
    wait_rsp(rd, rs, to);
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d;
    int          w_d;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rec;
    logic [1:0]  rs;
    logic        to;
    int          aw0, w0, b0, ar0, bad;

    vecs[0]  = '{1'b1, 6'h18, 32'h0000_0205, 4'hF, 0, 0, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 6'h18, 32'h0,         4'h0, 0, 0, 32'h0000_0205, 2'b00};
    vecs[2]  = '{1'b0, 6'h24, 32'h0,         4'h0, 0, 0, 32'h0000_03E7, 2'b00};
    vecs[3]  = '{1'b0, 6'h20, 32'h0,         4'h0, 0, 0, 32'h0001_0000, 2'b00};
    vecs[4]  = '{1'b0, 6'h3C, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, 2'b00};
    vecs[5]  = '{1'b1, 6'h10, 32'hAABB_CCDD, 4'h5, 0, 0, 32'h0,         2'b00};
    vecs[6]  = '{1'b0, 6'h10, 32'h0,         4'h0, 0, 0, 32'h11BB_33DD, 2'b00};
    vecs[7]  = '{1'b1, 6'h14, 32'h1234_5678, 4'hF, 4, 0, 32'h0,         2'b00};
    vecs[8]  = '{1'b1, 6'h1C, 32'hCAFE_F00D, 4'hF, 0, 4, 32'h0,         2'b00};
    vecs[9]  = '{1'b0, 6'h14, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00};
    vecs[10] = '{1'b0, 6'h1C, 32'h0,         4'h0, 0, 0, 32'hCAFE_F00D, 2'b00};
    vecs[11] = '{1'b1, 6'h38, 32'h5555_AAAA, 4'hF, 0, 0, 32'h0,         2'b10};
    vecs[12] = '{1'b0, 6'h38, 32'h0,         4'h0, 0, 0, 32'h0,         2'b10};

    // Reset state
    repeat (3) @(negedge aclk);
    check("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                         cmd_ready, rsp_valid, busy, rsp_timeout}, 9'h0);
    check("reset_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    areset = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("idle_b_r_ready", {m_axi_bready, m_axi_rready}, IDLE_RDY);
    @(negedge aclk);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      aw_delay = vecs[i].aw_d; w_delay = vecs[i].w_d;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_cnt; ar0 = ar_hs_cnt;
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, rs, to);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_resp_to", i), {rs, to}, {vecs[i].exp_resp, 1'b0});
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_hs_aw_w_b_ar", i),
              {8'(aw_hs_cnt - aw0), 8'(w_hs_cnt - w0), 8'(b_cnt - b0), 8'(ar_hs_cnt - ar0)},
              32'h0101_0100);
        check($sformatf("vec%0d_aw_minus_w", i), 64'(aw_hs_cyc - w_hs_cyc),
              64'(vecs[i].aw_d - vecs[i].w_d));
      end else begin
        check($sformatf("vec%0d_hs_aw_w_b_ar", i),
              {8'(aw_hs_cnt - aw0), 8'(w_hs_cnt - w0), 8'(b_cnt - b0), 8'(ar_hs_cnt - ar0)},
              32'h0000_0001);
      end
    end
    aw_delay = 0; w_delay = 0;

    // Response back-pressure: rsp held, a second command waits on cmd_valid
    ar0 = ar_hs_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h24;
    while (!cmd_ready) @(negedge aclk);
    @(negedge aclk);
    cmd_addr = 6'h20;
    bad = 0;
    while (!rsp_valid && bad < 200) begin @(negedge aclk); bad++; end
    rec = rsp_rdata;
    bad = 0;
    repeat (10) begin
      @(negedge aclk);
      if (!rsp_valid || rsp_rdata !== rec || cmd_ready || m_axi_arvalid) bad++;
    end
    check("hold_rdata", rec, 32'd999);
    check("hold_stable_cycles_bad", bad, 0);
    check("hold_ar_count", ar_hs_cnt - ar0, 1);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    wait_rsp(rd, rs, to);
    check("after_hold_rdata", rd, 32'h0001_0000);

    // Reset with AW pending
    aw_delay = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h30; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
    while (!cmd_ready) @(negedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge aclk);
    check("pre_reset_aw", {m_axi_awvalid, m_axi_awready, busy}, 3'b101);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("mid_reset_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy, rsp_valid}, 5'b0);
    @(negedge aclk);
    areset = 1'b0;
    aw_delay = 0;
    #1;
    check("post_reset_cmd_ready", cmd_ready, 1'b1);
    @(negedge aclk);
    do_cmd(1'b1, 6'h18, 32'h0000_0777, 4'h3, rd, rs, to);
    check("post_reset_wr_resp", rs, 2'b00);
    do_cmd(1'b0, 6'h18, 32'h0, 4'h0, rd, rs, to);
    check("post_reset_readback", rd, 32'h0000_0777);

`ifdef BITNET_AXIM_TIMEOUT_EN
    // Slave never accepts AR: transaction abandoned after TIMEOUT_CYCLES
    ar_never = 1'b1;
    do_cmd(1'b0, 6'h24, 32'h0, 4'h0, rd, rs, to);
    check("timeout_rsp", {to, rs, rd}, {1'b1, 2'b11, 32'h0});
    check("timeout_arvalid", m_axi_arvalid, 1'b0);
    ar_never = 1'b0;
    do_cmd(1'b0, 6'h24, 32'h0, 4'h0, rd, rs, to);
    check("after_timeout_rsp", {to, rs, rd}, {1'b0, 2'b00, 32'd999});
`endif

    check("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
